// File: rtl/reg_arb_pkg.sv
// ============================================================================
//  reg_arb_pkg : shared types and constants for the register-access arbiter
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/reg_arb_picker.sv
// ============================================================================
//  reg_arb_picker : two-port winner select; round-robin when ARB_ROUND_ROBIN_EN
//  is defined, otherwise fixed priority with A winning ties
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_arb_picker
  import reg_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a_valid,
  input  logic b_valid,
  input  logic grant_en,
  output logic any_valid,
  output logic winner
);

  assign any_valid = a_valid | b_valid;

`ifdef ARB_ROUND_ROBIN_EN
  // prio_q names the port that wins the next tie
  logic prio_q;
  logic prio_d;

  always_comb begin
    winner = GNT_A;
    if (a_valid && b_valid) winner = prio_q;
    else if (b_valid)       winner = GNT_B;

    prio_d = prio_q;
    if (grant_en && any_valid) prio_d = ~winner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= GNT_A;
    else     prio_q <= prio_d;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, grant_en};

  always_comb begin
    winner = GNT_A;
    if (!a_valid && b_valid) winner = GNT_B;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/reg_access_arbiter.sv
// ============================================================================
//  reg_access_arbiter : shares a single-port register array between port A
//  (SPI) and port B (host); 3-cycle accept/strobe/respond transactions.
//  Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  input  logic              a_req_write,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_req_ready,
  output logic              a_resp_valid,
  output logic [DATA_W-1:0] a_resp_rdata,
  input  logic              b_req_valid,
  input  logic              b_req_write,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_req_ready,
  output logic              b_resp_valid,
  output logic [DATA_W-1:0] b_resp_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              reg_write_enable,
  output logic              reg_read_enable,
  input  logic [DATA_W-1:0] reg_read_data
);

  state_e            state_q, state_d;
  logic              cmd_write_q, cmd_write_d;
  logic              cmd_gnt_q, cmd_gnt_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;

  logic              any_valid;
  logic              winner;
  logic              in_idle;
  logic              in_resp;
  logic [DATA_W-1:0] resp_data;

  assign in_idle = (state_q == IDLE);
  assign in_resp = (state_q == RESP);

  reg_arb_picker u_picker (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_req_valid),
    .b_valid   (b_req_valid),
    .grant_en  (in_idle),
    .any_valid (any_valid),
    .winner    (winner)
  );

  always_comb begin
    state_d     = state_q;
    cmd_write_d = cmd_write_q;
    cmd_gnt_d   = cmd_gnt_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d   = ISSUE;
          cmd_gnt_d = winner;
          if (winner == GNT_B) begin
            b_req_ready = 1'b1;
            cmd_write_d = b_req_write;
            cmd_addr_d  = b_req_addr;
            cmd_wdata_d = b_req_wdata;
          end else begin
            a_req_ready = 1'b1;
            cmd_write_d = a_req_write;
            cmd_addr_d  = a_req_addr;
            cmd_wdata_d = a_req_wdata;
          end
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_write_q <= 1'b0;
      cmd_gnt_q   <= GNT_A;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_write_q <= cmd_write_d;
      cmd_gnt_q   <= cmd_gnt_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  // Strobes come straight from the state flop so they cannot glitch and
  // collapse asynchronously with rst.
  assign reg_addr         = cmd_addr_q;
  assign reg_write_data   = cmd_wdata_q;
  assign reg_write_enable = (state_q == ISSUE) &  cmd_write_q;
  assign reg_read_enable  = (state_q == ISSUE) & ~cmd_write_q;

  assign resp_data    = cmd_write_q ? '0 : reg_read_data;
  assign a_resp_valid = in_resp & (cmd_gnt_q == GNT_A);
  assign b_resp_valid = in_resp & (cmd_gnt_q == GNT_B);
  assign a_resp_rdata = a_resp_valid ? resp_data : '0;
  assign b_resp_rdata = b_resp_valid ? resp_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_reg_access_arbiter.sv
// ============================================================================
//  tb_reg_access_arbiter : directed scoreboard bench for reg_access_arbiter
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req_valid, a_req_write, a_req_ready, a_resp_valid;
  logic [7:0]  a_req_addr;
  logic [15:0] a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_write, b_req_ready, b_resp_valid;
  logic [7:0]  b_req_addr;
  logic [15:0] b_req_wdata, b_resp_rdata;
  logic [7:0]  reg_addr;
  logic [15:0] reg_write_data, reg_read_data;
  logic        reg_write_enable, reg_read_enable;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] model [256];
  logic [15:0] mem   [256];
  logic        mem_clr;
  logic        rr_pref;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  reg_access_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .a_req_valid      (a_req_valid),
    .a_req_write      (a_req_write),
    .a_req_addr       (a_req_addr),
    .a_req_wdata      (a_req_wdata),
    .a_req_ready      (a_req_ready),
    .a_resp_valid     (a_resp_valid),
    .a_resp_rdata     (a_resp_rdata),
    .b_req_valid      (b_req_valid),
    .b_req_write      (b_req_write),
    .b_req_addr       (b_req_addr),
    .b_req_wdata      (b_req_wdata),
    .b_req_ready      (b_req_ready),
    .b_resp_valid     (b_resp_valid),
    .b_resp_rdata     (b_resp_rdata),
    .reg_addr         (reg_addr),
    .reg_write_data   (reg_write_data),
    .reg_write_enable (reg_write_enable),
    .reg_read_enable  (reg_read_enable),
    .reg_read_data    (reg_read_data)
  );

  // Stand-in register array with a registered read port
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (reg_write_enable) mem[reg_addr] <= reg_write_data;
      if (reg_read_enable)  reg_read_data <= mem[reg_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  wire [61:0] all_out = {a_req_ready, a_resp_valid, a_resp_rdata,
                         b_req_ready, b_resp_valid, b_resp_rdata,
                         reg_addr, reg_write_data, reg_write_enable, reg_read_enable};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic port, input logic wr, input logic [7:0] ad, input logic [15:0] wd);
    exp_t e;
    e.data = wr ? 16'h0 : model[ad];
    e.due  = cyc + 2;
    if (port) qb.push_back(e);
    else      qa.push_back(e);
    if (wr) model[ad] = wd;
    rr_pref = ~port;
  endtask

  // Response scoreboard plus per-cycle exclusivity checks
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (a_resp_valid) begin
        chk("a_resp_pending", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk("a_resp_rdata", a_resp_rdata, e.data);
          chk("a_resp_cycle", cyc, e.due);
        end
      end
      if (b_resp_valid) begin
        chk("b_resp_pending", qb.size() > 0, 1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk("b_resp_rdata", b_resp_rdata, e.data);
          chk("b_resp_cycle", cyc, e.due);
        end
      end
      chk("ready_onehot", a_req_ready & b_req_ready, 0);
      chk("enable_excl", reg_write_enable & reg_read_enable, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_pair(input logic a_en, input logic a_wr, input logic [7:0] a_ad, input logic [15:0] a_wd,
                          input logic b_en, input logic b_wr, input logic [7:0] b_ad, input logic [15:0] b_wd,
                          input int grants, input logic keep);
    int   got;
    logic exp_port;
    logic port;
    got = 0;
    a_req_valid = a_en; a_req_write = a_wr; a_req_addr = a_ad; a_req_wdata = a_wd;
    b_req_valid = b_en; b_req_write = b_wr; b_req_addr = b_ad; b_req_wdata = b_wd;
    for (int t = 0; t < 40 && got < grants; t++) begin
      @(negedge clk);
      if (a_req_ready || b_req_ready) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_port = (a_req_valid && b_req_valid) ? rr_pref : b_req_valid;
`else
        exp_port = !a_req_valid && b_req_valid;
`endif
        chk("grant_a", a_req_ready, !exp_port);
        chk("grant_b", b_req_ready, exp_port);
        port = b_req_ready;
        if (port) accept(1'b1, b_wr, b_ad, b_wd);
        else      accept(1'b0, a_wr, a_ad, a_wd);
        got++;
        @(posedge clk); #1;
        if (!keep) begin
          if (port) b_req_valid = 1'b0;
          else      a_req_valid = 1'b0;
        end
      end
    end
    chk("grants_done", got, grants);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1; rr_pref = 1'b0;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0;
    for (int i = 0; i < 256; i++) model[i] = '0;
    @(negedge clk);
    chk("reset_outputs", all_out, 0);
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;

    // Quiet after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("quiet_outputs", all_out, 0);
    end
    @(posedge clk); #1;

    // A write 0x12 <- 0xBEEF with cycle-exact strobe timing
    a_req_valid = 1; a_req_write = 1; a_req_addr = 8'h12; a_req_wdata = 16'hBEEF;
    @(negedge clk);
    chk("t1_ready_c0", a_req_ready, 1);
    chk("t1_we_c0", reg_write_enable, 0);
    accept(1'b0, 1'b1, 8'h12, 16'hBEEF);
    @(posedge clk); #1;
    a_req_valid = 0;
    @(negedge clk);
    chk("t1_we_c1", reg_write_enable, 1);
    chk("t1_re_c1", reg_read_enable, 0);
    chk("t1_addr_c1", reg_addr, 8'h12);
    chk("t1_wdata_c1", reg_write_data, 16'hBEEF);
    chk("t1_ready_c1", a_req_ready, 0);
    @(negedge clk);
    chk("t1_we_c2", reg_write_enable, 0);
    chk("t1_resp_c2", a_resp_valid, 1);
    idle(1);
    run_pair(1, 0, 8'h12, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // B write, then both ports read together
    run_pair(0, 0, 0, 0, 1, 1, 8'h34, 16'h5555, 1, 0);
    idle(3);
`ifdef ARB_ROUND_ROBIN_EN
    run_pair(1, 0, 8'h12, 0, 1, 0, 8'h34, 0, 4, 1);
`else
    run_pair(1, 0, 8'h12, 0, 1, 0, 8'h34, 0, 2, 0);
`endif
    idle(3);

    // B write 0xFF racing A read 0xFF; outcome follows the arbitration model
    run_pair(1, 1, 8'hFF, 16'h0BAD, 0, 0, 0, 0, 1, 0);
    idle(3);
    run_pair(1, 0, 8'hFF, 0, 1, 1, 8'hFF, 16'h1234, 2, 0);
    idle(3);
    run_pair(1, 0, 8'hFF, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // Reset during ISSUE of a write
    a_req_valid = 1; a_req_write = 1; a_req_addr = 8'h40; a_req_wdata = 16'hAAAA;
    @(negedge clk);
    chk("t4_ready", a_req_ready, 1);
    @(posedge clk); #1;
    a_req_valid = 0;
    #2;
    chk("t4_we_issue", reg_write_enable, 1);
    rst = 1'b1;
    #1;
    chk("t4_enables_async", {reg_write_enable, reg_read_enable}, 0);
    @(negedge clk);
    chk("t4_no_resp", a_resp_valid | b_resp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rr_pref = 1'b0;
    @(negedge clk);
    chk("t4_post_rst", {a_resp_valid, b_resp_valid, reg_write_enable, reg_read_enable}, 0);
    @(posedge clk); #1;
    run_pair(1, 0, 8'h40, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // Continuous A request: ready every third cycle
    a_req_valid = 1; a_req_write = 0; a_req_addr = 8'h12;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t5_ready", a_req_ready, (i % 3) == 0);
      chk("t5_re", reg_read_enable, (i % 3) == 1);
      if (a_req_ready) accept(1'b0, 1'b0, 8'h12, 16'h0);
    end
    @(posedge clk); #1;
    a_req_valid = 0;
    idle(4);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
